// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a writer and two readers.
// It drives the SRAM strobes, routes read data back to the reader that issued it, and counts conflicts.
module sram_port_arbiter #(
    parameter int AW = 14,
    parameter int DW = 112,
    parameter int CW = 16
) (
    input  logic          iClk,
    input  logic          iReset,
    input  logic          iWValid,
    input  logic [AW-1:0] iWAddr,
    input  logic [DW-1:0] iWData,
    output logic          oWReady,
    input  logic          iR0Valid,
    input  logic [AW-1:0] iR0Addr,
    output logic          oR0Ready,
    output logic          oR0RValid,
    input  logic          iR1Valid,
    input  logic [AW-1:0] iR1Addr,
    output logic          oR1Ready,
    output logic          oR1RValid,
    output logic [DW-1:0] oRData,
    output logic          oNCE,
    output logic          oNWRT,
    output logic [AW-1:0] oRA,
    output logic [DW-1:0] oDIN,
    input  logic [DW-1:0] iDO,
    output logic [CW-1:0] oConflictCnt,
    output logic          oIdle
);

    typedef enum logic [1:0] {
        SRC_W    = 2'd0,
        SRC_R0   = 2'd1,
        SRC_R1   = 2'd2,
        SRC_NONE = 2'd3
    } src_e;

    src_e          rLast_q, rLast_d;
    src_e          grant;
    logic [AW-1:0] raHold_q, raHold_d;
    logic [DW-1:0] dinHold_q, dinHold_d;
    logic          r0RValid_q, r1RValid_q;
    logic [CW-1:0] conflictCnt_q, conflictCnt_d;
    logic          conflict;

    // Search starts just after the last granted requester; reset suppresses every grant.
    always_comb begin
        grant = SRC_NONE;
        if (iReset) begin
            case (rLast_q)
                SRC_W: begin
                    if (iR0Valid)      grant = SRC_R0;
                    else if (iR1Valid) grant = SRC_R1;
                    else if (iWValid)  grant = SRC_W;
                end
                SRC_R0: begin
                    if (iR1Valid)      grant = SRC_R1;
                    else if (iWValid)  grant = SRC_W;
                    else if (iR0Valid) grant = SRC_R0;
                end
                default: begin
                    if (iWValid)       grant = SRC_W;
                    else if (iR0Valid) grant = SRC_R0;
                    else if (iR1Valid) grant = SRC_R1;
                end
            endcase
        end
    end

    assign conflict = (iWValid & iR0Valid) | (iWValid & iR1Valid) | (iR0Valid & iR1Valid);

    always_comb begin
        oWReady   = (grant == SRC_W);
        oR0Ready  = (grant == SRC_R0);
        oR1Ready  = (grant == SRC_R1);
        oNCE      = 1'b1;
        oNWRT     = 1'b1;
        oRA       = raHold_q;
        oDIN      = dinHold_q;
        rLast_d   = rLast_q;
        raHold_d  = raHold_q;
        dinHold_d = dinHold_q;
        case (grant)
            SRC_W: begin
                oNCE      = 1'b0;
                oNWRT     = 1'b0;
                oRA       = iWAddr;
                oDIN      = iWData;
                rLast_d   = SRC_W;
                raHold_d  = iWAddr;
                dinHold_d = iWData;
            end
            SRC_R0: begin
                oNCE     = 1'b0;
                oRA      = iR0Addr;
                rLast_d  = SRC_R0;
                raHold_d = iR0Addr;
            end
            SRC_R1: begin
                oNCE     = 1'b0;
                oRA      = iR1Addr;
                rLast_d  = SRC_R1;
                raHold_d = iR1Addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        conflictCnt_d = conflictCnt_q;
        if (conflict && (conflictCnt_q != {CW{1'b1}})) begin
            conflictCnt_d = conflictCnt_q + CW'(1);
        end
    end

    // Reset starts the pointer at R1 so the writer wins the first contested cycle.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            rLast_q       <= SRC_R1;
            raHold_q      <= '0;
            dinHold_q     <= '0;
            r0RValid_q    <= 1'b0;
            r1RValid_q    <= 1'b0;
            conflictCnt_q <= '0;
        end else begin
            rLast_q       <= rLast_d;
            raHold_q      <= raHold_d;
            dinHold_q     <= dinHold_d;
            r0RValid_q    <= (grant == SRC_R0);
            r1RValid_q    <= (grant == SRC_R1);
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign oR0RValid    = r0RValid_q;
    assign oR1RValid    = r1RValid_q;
    assign oRData       = iDO;
    assign oConflictCnt = conflictCnt_q;
    assign oIdle        = ~(iWValid | iR0Valid | iR1Valid) & ~r0RValid_q & ~r1RValid_q;

endmodule
